// File: rtl/icache_mem_emul.sv
// Memory model behind the icache miss path: in-order request FIFO, fixed or random
// response latency, and line data generated from the line address.
module icache_mem_emul #(
    parameter int LINE_WIDTH  = 128,
    parameter int PADDR_WIDTH = 56,
    parameter int TID_WIDTH   = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_LAT     = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              lat_rand_en_i,
    input  logic [7:0]                        lat_fixed_i,
    input  logic                              mem_req_i,
    output logic                              mem_ack_o,
    input  logic [PADDR_WIDTH-1:0]            mem_paddr_i,
    input  logic                              mem_nc_i,
    input  logic [TID_WIDTH-1:0]              mem_tid_i,
    output logic                              rtrn_vld_o,
    output logic [LINE_WIDTH-1:0]             rtrn_data_o,
    output logic [TID_WIDTH-1:0]              rtrn_tid_o,
    output logic                              rtrn_nc_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding_o
);
    localparam int NUM_WORDS = LINE_WIDTH / 32;
    localparam int OFF_W     = $clog2(LINE_WIDTH / 8);
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W     = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam logic [PADDR_WIDTH-1:0] OFF_MASK = PADDR_WIDTH'((1 << OFF_W) - 1);

    if (LINE_WIDTH % 32 != 0) begin : g_bad_line
        $fatal(1, "LINE_WIDTH must be a multiple of 32");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $fatal(1, "FIFO_DEPTH must be at least 2");
    end
    if (MAX_LAT < 0) begin : g_bad_lat
        $fatal(1, "MAX_LAT must be non-negative");
    end

    typedef struct packed {
        logic [PADDR_WIDTH-1:0] la;
        logic [TID_WIDTH-1:0]   tid;
        logic                   nc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    entry_t                fifo_q [FIFO_DEPTH];
    entry_t                head;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  push, pop;
    state_t                state;
    logic [LAT_W-1:0]      lat_cnt, lat_pick;
    logic [15:0]           lfsr;
    logic [LINE_WIDTH-1:0] head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ack looks at the pre-pop count, so a full FIFO blocks even while it drains.
    assign mem_ack_o     = mem_req_i && (count < CNT_W'(FIFO_DEPTH));
    assign push          = mem_req_i && mem_ack_o;
    assign pop           = (state == WAIT) && (lat_cnt == '0);
    assign head          = fifo_q[rd_ptr];
    assign outstanding_o = count;

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        assign head_data[w*32 +: 32] = 32'(head.la + PADDR_WIDTH'(4 * w));
    end

    always_comb begin
        lat_pick = '0;
        if (lat_rand_en_i)
            lat_pick = LAT_W'(32'(lfsr) % (MAX_LAT + 1));
        else if (32'(lat_fixed_i) > MAX_LAT)
            lat_pick = LAT_W'(MAX_LAT);
        else
            lat_pick = LAT_W'(lat_fixed_i);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr].la  <= mem_paddr_i & ~OFF_MASK;
            fifo_q[wr_ptr].tid <= mem_tid_i;
            fifo_q[wr_ptr].nc  <= mem_nc_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Free-running Galois LFSR feeds the random latency draw.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) lfsr <= 16'hACE1;
        else         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            rtrn_vld_o  <= 1'b0;
            rtrn_data_o <= '0;
            rtrn_tid_o  <= '0;
            rtrn_nc_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rtrn_vld_o <= 1'b0;
                    if (count != '0) begin
                        lat_cnt <= lat_pick;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else begin
                        rtrn_data_o <= head_data;
                        rtrn_tid_o  <= head.tid;
                        rtrn_nc_o   <= head.nc;
                        rtrn_vld_o  <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    rtrn_vld_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    rtrn_vld_o <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule
